// File: rtl/cb_mem_responder.sv
// cb_mem_responder: memory-backed target for the crossbar req/ack protocol.
// A wait-state FSM paces acceptance. Writes commit to a word array. Reads
// travel down a valid/data pipeline and return as a one-cycle _resp pulse.
module cb_mem_responder #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_DEPTH    = 256,
  parameter int ACK_WAIT     = 1,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  _req,
  input  logic [ADDR_WIDTH-1:0] _addr,
  input  logic                  _cmd,
  input  logic [DATA_WIDTH-1:0] _wdata,
  output logic                  _ack,
  output logic [DATA_WIDTH-1:0] _rdata,
  output logic                  _resp
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic {ST_WAIT, ST_ACK} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d;

  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             xfer;
  logic             wr_en;
  logic             rd_en;
  logic             unused_addr_lsb;

  // Word index from the byte address; the two byte-lane bits carry no meaning.
  assign idx             = _addr[IDX_W+1:2];
  assign unused_addr_lsb = ^_addr[1:0];

  generate
    if (ADDR_WIDTH > IDX_W + 2) begin : g_range
      assign in_range = ~|_addr[ADDR_WIDTH-1:IDX_W+2];
    end else begin : g_full
      assign in_range = 1'b1;
    end
  endgenerate

  // A transfer only happens if the initiator still holds _req in the ACK cycle.
  assign xfer  = ack_q & _req;
  assign wr_en = xfer & _cmd & in_range;
  assign rd_en = xfer & ~_cmd;

  // Wait-state FSM: count request cycles, raise _ack for exactly one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (!_req) begin
          cnt_d = 4'd0;
        end else if (cnt_q == 4'(ACK_WAIT)) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_WAIT;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM and acknowledge registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

  // Word array with registered read; contents are deliberately not reset.
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_word_q;

  // Array write port and synchronous read port (read returns pre-write data).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= _wdata;
    end
    rd_word_q <= mem[idx];
  end

  // Out-of-range reads must return zero, so remember the range of the sample.
  logic rd_inr_q, rd_inr_d;
  assign rd_inr_d = in_range;

  // Range flag travels alongside the array read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_inr_q <= 1'b0;
    end else begin
      rd_inr_q <= rd_inr_d;
    end
  end

  // Read pipeline: stage 0 is the array read register; later stages are flops.
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0]   stage_data [READ_LATENCY];

  genvar gi;
  generate
    for (gi = 0; gi < READ_LATENCY; gi++) begin : g_pipe
      if (gi == 0) begin : g_first
        assign vld_d[gi]      = rd_en;
        assign stage_data[gi] = rd_inr_q ? rd_word_q : '0;
      end else begin : g_next
        logic [DATA_WIDTH-1:0] data_q, data_d;
        assign vld_d[gi]      = vld_q[gi-1];
        assign data_d         = stage_data[gi-1];
        assign stage_data[gi] = data_q;

        // Data stage register.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            data_q <= '0;
          end else begin
            data_q <= data_d;
          end
        end
      end
    end
  endgenerate

  // Valid bits; reset drops every in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign _ack   = ack_q;
  assign _resp  = vld_q[READ_LATENCY-1];
  assign _rdata = vld_q[READ_LATENCY-1] ? stage_data[READ_LATENCY-1] : '0;

endmodule

// File: doc/cb_mem_responder.md
# cb_mem_responder

Memory-backed responder for the crossbar request/response protocol: `_req`, `_addr`, `_cmd`, `_wdata` in; `_ack`, `_rdata`, `_resp` out. It sits at a crossbar slave port and acts as the target end of the initiator-driven handshake. It accepts one request per handshake after a programmable wait-state count, commits writes to an internal word array, and returns read data as a `_resp` pulse after a fixed pipeline latency. Multiple reads may be outstanding.

## Interface
- `ADDR_WIDTH`, default 32: address width, byte address.
- `DATA_WIDTH`, default 32: data width. Word = `DATA_WIDTH/8` bytes.
- `MEM_DEPTH`, default 256: number of words. Must be a power of 2.
- `ACK_WAIT`, default 1: wait cycles inserted before `_ack`. Range 0..15.
- `READ_LATENCY`, default 2: cycles from the handshake cycle to the `_resp` cycle. Range 1..8.

Ports:
- `clk`, input, 1: single clock; all logic is on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `_req`, input, 1: request valid.
- `_addr`, input, ADDR_WIDTH: byte address. Bits [1:0] are ignored.
- `_cmd`, input, 1: 0 = read, 1 = write.
- `_wdata`, input, DATA_WIDTH: write data.
- `_ack`, output, 1: request accepted this cycle. Registered.
- `_rdata`, output, DATA_WIDTH: read data. Valid only while `_resp`=1, otherwise 0.
- `_resp`, output, 1: one-cycle read-response pulse. Registered.

## Operation
- Handshake: a transfer occurs in cycle T when `_req`=1 and `_ack`=1.
  - The initiator holds `_addr`, `_cmd` and `_wdata` stable from `_req` rise through T.
- Wait-state FSM, 2 states:
  - WAIT: `cnt` increments each cycle `_req`=1. If `_req`=0, `cnt` clears to 0.
  - When `_req`=1 and `cnt`==ACK_WAIT, the FSM registers `_ack`=1 for the next cycle and enters ACK.
  - ACK: lasts exactly one cycle (the handshake cycle), `cnt`=0, then returns to WAIT.
  - If `_req` drops during ACK (protocol violation), no transfer occurs and no memory or response effect.
- Index = `_addr[log2(MEM_DEPTH)+1:2]`. In range means upper bits `_addr[ADDR_WIDTH-1:log2(MEM_DEPTH)+2]` are all 0.
- Write (`_cmd`=1) at handshake:
  - `mem[index]` ← `_wdata` at the end of T.
  - Out-of-range write is dropped.
  - No `_resp` is issued for a write.
- Read (`_cmd`=0) at handshake:
  - `mem[index]` is sampled at the end of T. An out-of-range read samples 0.
  - The sample enters a READ_LATENCY-deep valid/data shift pipeline.
  - One entry per read; up to READ_LATENCY reads in flight.
- Memory contents are not reset (X after power-up). All control and output registers are reset.
- Read-after-write to the same word in the next handshake returns the new data.

## Timing
- Reset (`rst_n`=0, asynchronous): `_ack`=0, `_resp`=0, `_rdata`=0, FSM=WAIT, `cnt`=0, pipeline valids=0.
  - In-flight reads are discarded and never produce `_resp`.
  - Deassertion is synchronous to `clk` by the parent.
- `_ack` latency: with `_req` rising in cycle R, `_ack`=1 in cycle R+ACK_WAIT+1.
  - ACK_WAIT=0 gives minimum 1-cycle latency.
- Back-to-back with `_req` held high: next `_ack` comes ACK_WAIT+2 cycles after the previous `_ack`.
  - ACK_WAIT=0 gives one transfer every 2 cycles.
- Read response: `_resp`=1 and `_rdata` valid in cycle T+READ_LATENCY, for exactly 1 cycle.
  - There is no backpressure; the initiator must accept it.
- Responses return strictly in handshake order.
- `_rdata` is forced to 0 in any cycle with `_resp`=0.

## Test plan
- Reset:
  - Assert `rst_n`=0 mid-read, with 2 reads in flight at READ_LATENCY=3.
  - Required: `_ack`/`_resp`/`_rdata` are 0 immediately (asynchronously), and no `_resp` appears after release.
- Write then read, ACK_WAIT=1, READ_LATENCY=2:
  - Write `0x0000_0010` ← `0xCAFE_F00D`, then read `0x10`.
  - Required: `_ack` 2 cycles after each `_req` rise; `_resp`=1 with `_rdata`=`0xCAFE_F00D` exactly 2 cycles after the read `_ack`; no `_resp` for the write.
- Pipelined reads, ACK_WAIT=0, READ_LATENCY=3:
  - Three reads of words 1, 2, 3 (preloaded 0x11, 0x22, 0x33) with `_req` held high.
  - Required: `_ack` every 2 cycles; `_resp` pulses in order with `_rdata` 0x11, 0x22, 0x33, each 3 cycles after its `_ack`.
- Out of range, MEM_DEPTH=256:
  - Write `0x0000_0400` ← `0xFFFF_FFFF`, then read `0x0000_0400` and `0x0000_0000`.
  - Required: the out-of-range read returns 0, and word 0 is unchanged.
- Aborted request:
  - `_req` pulses high for 1 cycle at ACK_WAIT=3.
  - Required: no `_ack`, `cnt` returns to 0, and a later full request is acked after 4 wait cycles.
- Address low bits:
  - Write `0x0000_0007` ← `0xA5A5_A5A5`, then read `0x0000_0004`.
  - Required: `_rdata`=`0xA5A5_A5A5`.
